// File: rtl/counter_if.sv
// Counter enable/status bundle: the client drives the enable and observes
// the registered count and the wrap pulse.
interface counter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             en;
  logic [WIDTH-1:0] count;
  logic             ovf;

  modport master (output en, input count, input ovf);
  modport slave  (input en, output count, output ovf);
endinterface

// File: rtl/counter.sv
// Enable-gated modulo up-counter with a registered one-cycle wrap pulse,
// usable as a timebase or cascaded through ovf into another counter's enable.
module counter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_COUNT = (32'd1 << WIDTH) - 32'd1
) (
  input  logic     clk,
  input  logic     rst,
  counter_if.slave bus
);

  localparam logic [WIDTH-1:0] max_c  = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] one_c  = WIDTH'(32'd1);
  localparam logic [WIDTH-1:0] zero_c = {WIDTH{1'b0}};

  logic [1:0]       rst_sync_r;
  logic             run_s;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_nxt_s;
  logic             ovf_r;
  logic             ovf_nxt_s;

  // Reset release synchroniser: assertion is immediate, release takes two edges
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign run_s = rst_sync_r[1];

  // Next count and wrap pulse; any value at or above the terminal wraps
  always_comb begin
    count_nxt_s = count_r;
    ovf_nxt_s   = 1'b0;
    if (!run_s) begin
      count_nxt_s = zero_c;
      ovf_nxt_s   = 1'b0;
    end else if (bus.en) begin
      if (count_r >= max_c) begin
        count_nxt_s = zero_c;
        ovf_nxt_s   = 1'b1;
      end else begin
        count_nxt_s = count_r + one_c;
        ovf_nxt_s   = 1'b0;
      end
    end else begin
      count_nxt_s = count_r;
      ovf_nxt_s   = 1'b0;
    end
  end

  // Count and overflow output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= zero_c;
      ovf_r   <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      ovf_r   <= ovf_nxt_s;
    end
  end

  assign bus.count = count_r;
  assign bus.ovf   = ovf_r;

endmodule

// File: tb/tb_counter.sv
// Directed bench for counter: default 8-bit instance and a modulo-10 instance
// sharing one clock, each with its own reset.
module tb_counter;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   checks;
  int   errors;
  int   gap;

  counter_if #(.WIDTH(8)) ba ();
  counter_if #(.WIDTH(4)) bb ();

  counter #(.WIDTH(8), .MAX_COUNT(255)) dut_a (.clk(clk), .rst(rst_a), .bus(ba));
  counter #(.WIDTH(4), .MAX_COUNT(9))   dut_b (.clk(clk), .rst(rst_b), .bus(bb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input int exp_cnt, input int exp_ovf);
    chk({tag, ".count"}, {24'd0, ba.count}, exp_cnt);
    chk({tag, ".ovf"},   {31'd0, ba.ovf},   exp_ovf);
  endtask

  task automatic chk_b(input string tag, input int exp_cnt, input int exp_ovf);
    chk({tag, ".count"}, {28'd0, bb.count}, exp_cnt);
    chk({tag, ".ovf"},   {31'd0, bb.ovf},   exp_ovf);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_a  = 1'b0;
    rst_b  = 1'b0;
    ba.en  = 1'b1;
    bb.en  = 1'b0;

    // reset held with enable high
    for (int i = 0; i < 10; i++) begin
      step();
      chk_a("rst_hold", 0, 0);
    end
    chk_b("rst_hold_b", 0, 0);

    // release: two synchroniser edges, then count up
    rst_a = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      chk_a("basic", (k <= 2) ? 0 : k - 2, 0);
    end

    // asynchronous reset mid-cycle clears before next edge
    #2 rst_a = 1'b0;
    #1 chk_a("async_rst", 0, 0);
    step();
    rst_a = 1'b1;
    for (int k = 1; k <= 7; k++) step();
    chk_a("reach5", 5, 0);

    // enable gating 1,0,0,1
    ba.en = 1'b1; step(); chk_a("gate1", 6, 0);
    ba.en = 1'b0; step(); chk_a("gate2", 6, 0);
    ba.en = 1'b0; step(); chk_a("gate3", 6, 0);
    ba.en = 1'b1; step(); chk_a("gate4", 7, 0);

    // wrap 254, 255, 0
    repeat (247) step();
    chk_a("pre_wrap", 254, 0);
    step(); chk_a("at_max", 255, 0);
    step(); chk_a("wrap", 0, 1);

    // next pulse exactly 256 cycles later
    gap = 0;
    do begin
      step();
      gap++;
    end while (ba.ovf !== 1'b1 && gap < 300);
    chk("ovf_period", gap, 256);
    chk_a("period_wrap", 0, 1);

    // park at 255 with enable low, then wrap
    repeat (255) step();
    chk_a("park", 255, 0);
    ba.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_a("hold_max", 255, 0);
    end
    ba.en = 1'b1;
    step(); chk_a("late_wrap", 0, 1);

    // reset during the ovf pulse forgets it
    #2 rst_a = 1'b0;
    #1 chk_a("rst_in_ovf", 0, 0);
    step(); chk_a("rst_in_ovf_hold", 0, 0);
    rst_a = 1'b1;

    // modulo-10 instance
    bb.en = 1'b1;
    rst_b = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      step();
      chk_b("mod10", (k <= 2) ? 0 : (k - 2) % 10,
            (k >= 12 && (k - 2) % 10 == 0) ? 1 : 0);
    end
    chk_b("mod10_at9", 9, 0);
    #2 rst_b = 1'b0;
    #1 chk_b("mod10_rst", 0, 0);
    step(); chk_b("mod10_rst_hold", 0, 0);
    rst_b = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
